// File: rtl/decoder_rst_sequencer_pkg.sv
// Shared definitions for the restart-class sequencer: state encoding,
// RST opcode match pattern and the default vector spacing.
package decoder_rst_sequencer_pkg;

  // State codes double as the xpt phase number.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEC_HI = 3'd1,
    ST_WR_HI  = 3'd2,
    ST_DEC_LO = 3'd3,
    ST_WR_LO  = 3'd4,
    ST_LOAD   = 3'd5
  } rst_state_t;

  localparam logic [7:0] RST_OPC_MASK  = 8'b1100_0111;
  localparam logic [7:0] RST_OPC_VALUE = 8'b1100_0111;

  localparam int DEFAULT_VEC_STEP = 8;

  function automatic logic is_rst_opcode(input logic [7:0] op);
    return (op & RST_OPC_MASK) == RST_OPC_VALUE;
  endfunction

endpackage

// File: rtl/decoder_rst_vector_gen.sv
// Combinational vector index -> target address (base + index * step).
// Latency: zero cycles; no flow control.
module decoder_rst_vector_gen #(
  parameter int ADDR_W   = 16,
  parameter int VEC_BITS = 3,
  parameter int VEC_STEP = 8,
  parameter int VEC_BASE = 0
) (
  input  logic [VEC_BITS-1:0] index,
  output logic [ADDR_W-1:0]   addr
);

  // Step is a power of two, so the multiply collapses to a shift.
  localparam int STEP_SHIFT = $clog2(VEC_STEP);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] offset;

  assign base   = ADDR_W'(VEC_BASE);
  assign offset = ADDR_W'(index) << STEP_SHIFT;
  assign addr   = base + offset;

endmodule

// File: rtl/decoder_rst_sequencer.sv
// Restart sequencer: push PC high/low onto the stack, then load the vector.
// Launch to done in 5 cycles minimum; each mem_ready=0 cycle in a write phase adds one.
module decoder_rst_sequencer
  import decoder_rst_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int XPT_W    = 5,
  parameter int VEC_BITS = 3,
  parameter int VEC_STEP = DEFAULT_VEC_STEP,
  parameter int VEC_BASE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          opcode,
  input  logic                irq_take,
  input  logic [VEC_BITS-1:0] irq_vector,
  input  logic                mem_ready,
  output logic                busy,
  output logic [XPT_W-1:0]    xpt,
  output logic                sp_dec,
  output logic                sel_dt_pc_high,
  output logic                sel_dt_pc_low,
  output logic                sel_ad_sp,
  output logic                mem_write,
  output logic                pc_load,
  output logic [ADDR_W-1:0]   pc_vector,
  output logic                done,
  output logic                illegal
);

  rst_state_t          state;
  rst_state_t          state_next;
  logic                launch;
  logic                illegal_set;
  logic                opc_match;
  logic [VEC_BITS-1:0] launch_index;
  logic [ADDR_W-1:0]   vec_addr;
  logic [2:0]          state_bits;

  assign opc_match    = is_rst_opcode(opcode);
  // Interrupt acknowledge wins over a same-cycle decoder request.
  assign launch_index = irq_take ? irq_vector : VEC_BITS'(opcode[5:3]);

  decoder_rst_vector_gen #(
    .ADDR_W   (ADDR_W),
    .VEC_BITS (VEC_BITS),
    .VEC_STEP (VEC_STEP),
    .VEC_BASE (VEC_BASE)
  ) u_vector_gen (
    .index (launch_index),
    .addr  (vec_addr)
  );

  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    illegal_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (irq_take) begin
          launch = 1'b1;
        end else if (start) begin
          if (opc_match) launch = 1'b1;
          else           illegal_set = 1'b1;
        end
        if (launch) state_next = ST_DEC_HI;
      end
      ST_DEC_HI: state_next = ST_WR_HI;
      ST_WR_HI:  if (mem_ready) state_next = ST_DEC_LO;
      ST_DEC_LO: state_next = ST_WR_LO;
      ST_WR_LO:  if (mem_ready) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc_vector <= '0;
      illegal   <= 1'b0;
    end else begin
      state   <= state_next;
      illegal <= illegal_set;
      if (launch) pc_vector <= vec_addr;
    end
  end

  assign state_bits     = state;
  assign xpt            = XPT_W'(state_bits);
  assign busy           = (state != ST_IDLE);
  assign sp_dec         = (state == ST_DEC_HI) || (state == ST_DEC_LO);
  assign sel_dt_pc_high = (state == ST_WR_HI);
  assign sel_dt_pc_low  = (state == ST_WR_LO);
  assign sel_ad_sp      = (state == ST_WR_HI) || (state == ST_WR_LO);
  assign mem_write      = sel_ad_sp;
  assign pc_load        = (state == ST_LOAD);
  assign done           = (state == ST_LOAD);

endmodule

// File: tb/tb_decoder_rst_sequencer.sv
// Directed bench for decoder_rst_sequencer: default instance plus a
// VEC_STEP=16 / VEC_BASE=0x1000 instance sharing clock and reset.
module tb_decoder_rst_sequencer;

  // {busy, sp_dec, sel_hi, sel_lo, sel_ad_sp, mem_write, pc_load, done}
  localparam logic [7:0] S_IDLE = 8'b0000_0000;
  localparam logic [7:0] S_DHI  = 8'b1100_0000;
  localparam logic [7:0] S_WHI  = 8'b1010_1100;
  localparam logic [7:0] S_DLO  = 8'b1100_0000;
  localparam logic [7:0] S_WLO  = 8'b1001_1100;
  localparam logic [7:0] S_LOAD = 8'b1000_0011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, irq_take, mem_ready;
  logic [7:0]  opcode;
  logic [2:0]  irq_vector;
  logic        busy, sp_dec, sel_dt_pc_high, sel_dt_pc_low, sel_ad_sp;
  logic        mem_write, pc_load, done, illegal;
  logic [4:0]  xpt;
  logic [15:0] pc_vector;
  logic [7:0]  strb;

  logic        start2, irq_take2, mem_ready2;
  logic [7:0]  opcode2;
  logic [2:0]  irq_vector2;
  logic        busy2, sp_dec2, sel_hi2, sel_lo2, sel_ad_sp2;
  logic        mem_write2, pc_load2, done2, illegal2;
  logic [4:0]  xpt2;
  logic [15:0] pc_vector2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign strb = {busy, sp_dec, sel_dt_pc_high, sel_dt_pc_low,
                 sel_ad_sp, mem_write, pc_load, done};

  decoder_rst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .irq_take(irq_take), .irq_vector(irq_vector), .mem_ready(mem_ready),
    .busy(busy), .xpt(xpt), .sp_dec(sp_dec),
    .sel_dt_pc_high(sel_dt_pc_high), .sel_dt_pc_low(sel_dt_pc_low),
    .sel_ad_sp(sel_ad_sp), .mem_write(mem_write), .pc_load(pc_load),
    .pc_vector(pc_vector), .done(done), .illegal(illegal)
  );

  decoder_rst_sequencer #(.VEC_STEP(16), .VEC_BASE('h1000)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .opcode(opcode2),
    .irq_take(irq_take2), .irq_vector(irq_vector2), .mem_ready(mem_ready2),
    .busy(busy2), .xpt(xpt2), .sp_dec(sp_dec2),
    .sel_dt_pc_high(sel_hi2), .sel_dt_pc_low(sel_lo2),
    .sel_ad_sp(sel_ad_sp2), .mem_write(mem_write2), .pc_load(pc_load2),
    .pc_vector(pc_vector2), .done(done2), .illegal(illegal2)
  );

  // Data-select strobes must never overlap.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (sel_dt_pc_high && sel_dt_pc_low) begin
        errors++;
        $display("FAIL sel_exclusive got hi=%b lo=%b want not both", sel_dt_pc_high, sel_dt_pc_low);
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    start = 0; irq_take = 0; mem_ready = 1; opcode = 8'h00; irq_vector = 3'd0;
    start2 = 0; irq_take2 = 0; mem_ready2 = 1; opcode2 = 8'h00; irq_vector2 = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (xpt !== 5'd0) begin errors++; $display("FAIL reset_xpt got %0d want 0", xpt); end
    checks++;
    if (strb !== S_IDLE) begin errors++; $display("FAIL reset_strobes got %b want %b", strb, S_IDLE); end
    checks++;
    if (pc_vector !== 16'h0000) begin errors++; $display("FAIL reset_pc_vector got %h want 0000", pc_vector); end
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] exp_strb [0:4];
    logic [4:0] exp_x;
    exp_strb = '{S_DHI, S_WHI, S_DLO, S_WLO, S_LOAD};
    start = 1; opcode = 8'hFF; mem_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 0;
      exp_x = 5'(k + 1);
      checks++;
      if (xpt !== exp_x) begin errors++; $display("FAIL basic_xpt cycle %0d got %0d want %0d", k + 1, xpt, exp_x); end
      checks++;
      if (strb !== exp_strb[k]) begin errors++; $display("FAIL basic_strobes cycle %0d got %b want %b", k + 1, strb, exp_strb[k]); end
    end
    @(negedge clk);
    checks++;
    if (strb !== S_IDLE || xpt !== 5'd0) begin errors++; $display("FAIL basic_return_idle got strb=%b xpt=%0d want 0/0", strb, xpt); end
    checks++;
    if (pc_vector !== 16'h0038) begin errors++; $display("FAIL basic_pc_vector got %h want 0038", pc_vector); end
  endtask

  task automatic test_wait_states;
    logic [7:0] exp_strb [0:7];
    logic [4:0] exp_x    [0:7];
    logic       rdy      [0:7];
    exp_strb = '{S_DHI, S_WHI, S_WHI, S_WHI, S_WHI, S_DLO, S_WLO, S_LOAD};
    exp_x    = '{5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd3, 5'd4, 5'd5};
    rdy      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    start = 1; opcode = 8'hCF; mem_ready = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (xpt !== exp_x[k]) begin errors++; $display("FAIL wait_xpt cycle %0d got %0d want %0d", k + 1, xpt, exp_x[k]); end
      checks++;
      if (strb !== exp_strb[k]) begin errors++; $display("FAIL wait_strobes cycle %0d got %b want %b", k + 1, strb, exp_strb[k]); end
      mem_ready = rdy[k];
    end
    mem_ready = 1;
    @(negedge clk);
    checks++;
    if (strb !== S_IDLE) begin errors++; $display("FAIL wait_return_idle got %b want %b", strb, S_IDLE); end
    checks++;
    if (pc_vector !== 16'h0008) begin errors++; $display("FAIL wait_pc_vector got %h want 0008", pc_vector); end
  endtask

  task automatic test_illegal;
    logic [7:0] ops [0:1];
    ops = '{8'hC6, 8'h3E};
    for (int k = 0; k < 2; k++) begin
      start = 1; opcode = ops[k];
      @(negedge clk);
      start = 0;
      checks++;
      if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse op=%h got %b want 1", ops[k], illegal); end
      checks++;
      if (strb !== S_IDLE) begin errors++; $display("FAIL illegal_strobes op=%h got %b want %b", ops[k], strb, S_IDLE); end
      @(negedge clk);
      checks++;
      if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle op=%h got %b want 0", ops[k], illegal); end
      checks++;
      if (strb !== S_IDLE || xpt !== 5'd0) begin errors++; $display("FAIL illegal_stay_idle op=%h got strb=%b xpt=%0d want 0/0", ops[k], strb, xpt); end
    end
    checks++;
    if (pc_vector !== 16'h0008) begin errors++; $display("FAIL illegal_pc_kept got %h want 0008", pc_vector); end
  endtask

  task automatic test_irq_priority;
    int n_done = 0;
    int n_ill  = 0;
    irq_take = 1; irq_vector = 3'd2; start = 1; opcode = 8'hFF; mem_ready = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (illegal === 1'b1) n_ill++;
      if (k == 0) begin
        irq_take = 0; start = 0;
        checks++;
        if (xpt !== 5'd1) begin errors++; $display("FAIL irq_launch_xpt got %0d want 1", xpt); end
        checks++;
        if (pc_vector !== 16'h0010) begin errors++; $display("FAIL irq_pc_vector got %h want 0010", pc_vector); end
      end
      // Requests while busy must be dropped.
      if (k == 1) begin start = 1; opcode = 8'hFF; end
      if (k == 2) begin start = 0; irq_take = 1; irq_vector = 3'd7; end
      if (k == 3) irq_take = 0;
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL irq_single_sequence got %0d done pulses want 1", n_done); end
    checks++;
    if (n_ill != 0) begin errors++; $display("FAIL irq_no_illegal got %0d illegal pulses want 0", n_ill); end
    checks++;
    if (pc_vector !== 16'h0010 || xpt !== 5'd0) begin errors++; $display("FAIL irq_final got pc=%h xpt=%0d want 0010/0", pc_vector, xpt); end
  endtask

  task automatic test_reset_mid;
    int n_bad = 0;
    int lat   = 0;
    start = 1; opcode = 8'hFF; mem_ready = 1;
    repeat (3) begin
      @(negedge clk);
      start = 0;
    end
    checks++;
    if (xpt !== 5'd3) begin errors++; $display("FAIL rstmid_in_dec_lo got %0d want 3", xpt); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if (xpt !== 5'd0 || strb !== S_IDLE) begin errors++; $display("FAIL rstmid_idle got xpt=%0d strb=%b want 0/%b", xpt, strb, S_IDLE); end
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || pc_load !== 1'b0 || busy !== 1'b0) n_bad++;
    end
    checks++;
    if (n_bad != 0) begin errors++; $display("FAIL rstmid_no_done got %0d bad cycles want 0", n_bad); end
    start = 1; opcode = 8'hEF;
    while (lat < 12) begin
      @(negedge clk);
      start = 0;
      lat++;
      if (done === 1'b1) break;
    end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL rstmid_restart_latency got %0d want 5", lat); end
    checks++;
    if (pc_vector !== 16'h0028) begin errors++; $display("FAIL rstmid_restart_pc got %h want 0028", pc_vector); end
    @(negedge clk);
  endtask

  task automatic test_param_vectors;
    logic [7:0]  ops  [0:1];
    logic [15:0] exps [0:1];
    int lat;
    ops  = '{8'hDF, 8'hFF};
    exps = '{16'h1030, 16'h1070};
    for (int k = 0; k < 2; k++) begin
      start2 = 1; opcode2 = ops[k];
      @(negedge clk);
      start2 = 0;
      checks++;
      if (pc_vector2 !== exps[k] || xpt2 !== 5'd1) begin errors++; $display("FAIL param_pc op=%h got pc=%h xpt=%0d want %h/1", ops[k], pc_vector2, xpt2, exps[k]); end
      lat = 1;
      while (lat < 12 && done2 !== 1'b1) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL param_latency op=%h got %0d want 5", ops[k], lat); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_illegal();
    test_irq_priority();
    test_reset_mid();
    test_param_vectors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
